// File: rtl/video_jb_pkg.sv
// Shared definitions for the VIC IIe jailbar generator and compensator:
// FSM state encoding, phase/bin geometry, luma weights and a saturating
// pixel subtract helper.
package video_jb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SUM,
        ST_APPLY
    } jb_state_e;

    localparam int unsigned JB_PHASE_RELOAD = 24;
    localparam int unsigned JB_BINS         = 16;
    localparam int unsigned JB_BIN_W        = 4;
    localparam int unsigned JB_PHASE_W      = 6;
    localparam int unsigned JB_PIX_W        = 8;
    localparam int unsigned JB_TBL_W        = 4;
    localparam int unsigned JB_TOT_W        = 12;

    // Luma approximation shared with the generator: (10R + 19G + 3B) >> 5.
    localparam int unsigned JB_W_R          = 10;
    localparam int unsigned JB_W_G          = 19;
    localparam int unsigned JB_W_B          = 3;
    localparam int unsigned JB_LUMA_SHIFT   = 5;
    localparam int unsigned JB_PROD_W       = 13;

    // x - t, floored at zero.
    function automatic logic [JB_PIX_W-1:0] jb_sat_sub(
        input logic [JB_PIX_W-1:0] x,
        input logic [JB_TBL_W-1:0] t
    );
        logic [JB_PIX_W-1:0] t_ext;
        t_ext = JB_PIX_W'(t);
        return (x >= t_ext) ? (x - t_ext) : '0;
    endfunction

endpackage

// File: rtl/video_viciie_jb_comp_if.sv
// Pixel stream bundle: input pixel + syncs toward the compensator and the
// corrected pixel + delayed syncs coming back.
//   master: video source / sink side (drives Ri/Gi/Bi, hsync, vsync, de)
//   slave : compensator side (drives Ro/Go/Bo, hsync_o, vsync_o, de_o)
interface video_viciie_jb_comp_if;
    import video_jb_pkg::*;

    logic                hsync;
    logic                vsync;
    logic                de;
    logic [JB_PIX_W-1:0] Ri;
    logic [JB_PIX_W-1:0] Gi;
    logic [JB_PIX_W-1:0] Bi;
    logic [JB_PIX_W-1:0] Ro;
    logic [JB_PIX_W-1:0] Go;
    logic [JB_PIX_W-1:0] Bo;
    logic                hsync_o;
    logic                vsync_o;
    logic                de_o;

    modport master (
        output hsync, vsync, de, Ri, Gi, Bi,
        input  Ro, Go, Bo, hsync_o, vsync_o, de_o
    );

    modport slave (
        input  hsync, vsync, de, Ri, Gi, Bi,
        output Ro, Go, Bo, hsync_o, vsync_o, de_o
    );
endinterface

// File: rtl/video_jb_luma.sv
// Combinational 8-bit luma from RGB, shared with the jailbar generator.
//   r, g, b : input pixel
//   luma8_c : (10r + 19g + 3b) >> 5, always within 0..255
module video_jb_luma
    import video_jb_pkg::*;
(
    input  logic [JB_PIX_W-1:0] r,
    input  logic [JB_PIX_W-1:0] g,
    input  logic [JB_PIX_W-1:0] b,
    output logic [JB_PIX_W-1:0] luma8_c
);
    logic [JB_PROD_W-1:0] acc_c;

    always_comb begin
        acc_c = (JB_PROD_W'(r) * JB_PROD_W'(JB_W_R))
              + (JB_PROD_W'(g) * JB_PROD_W'(JB_W_G))
              + (JB_PROD_W'(b) * JB_PROD_W'(JB_W_B));
        luma8_c = JB_PIX_W'(acc_c >> JB_LUMA_SHIFT);
    end
endmodule

// File: rtl/video_viciie_jb_comp.sv
// VIC IIe jailbar compensator. Learns the mean brightness of each of 16
// two-clock phase bins (hsync-locked, 32-clock period) over a whole frame,
// turns the excess over the global mean into a 4-bit offset table during
// vblank, and subtracts the offset from every pixel.
//   clk, reset_n : pixel clock, async active-low reset
//   mode         : 0 = registered bypass, 1 = compensate
//   vif          : pixel stream in/out (slave side), outputs 1 clock latency
//   locked       : set by the first completed table update
module video_viciie_jb_comp
    import video_jb_pkg::*;
#(
    parameter int unsigned K = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         mode,
    video_viciie_jb_comp_if.slave        vif,
    output logic                         locked
);
    localparam int unsigned SUM_W = JB_PIX_W + K;
    localparam int unsigned CNT_W = K + 1;

    jb_state_e               state_q, state_d;
    logic [JB_PHASE_W-1:0]   cnt_q;
    logic [JB_PHASE_W-1:0]   phase_c;
    logic [JB_BIN_W-1:0]     bin_c;
    logic                    vs_prev_q;
    logic                    vs_rise_c;
    logic [JB_PIX_W-1:0]     luma_c;
    logic [SUM_W-1:0]        sum_q     [JB_BINS];
    logic [CNT_W-1:0]        cnt_bin_q [JB_BINS];
    logic [JB_BINS-1:0]      full_c;
    logic [JB_TBL_W-1:0]     tbl_q     [JB_BINS];
    logic [JB_TBL_W-1:0]     tbl_sel_c;
    logic [JB_BIN_W-1:0]     idx_q;
    logic [JB_TOT_W-1:0]     total_q;
    logic [JB_PIX_W-1:0]     avg_c;
    logic [JB_PIX_W-1:0]     mean_c;
    logic [JB_PIX_W:0]       diff_c;
    logic [JB_TBL_W-1:0]     tbl_wr_c;
    logic                    clr_c, acc_en_c, sum_en_c, apply_en_c, lock_set_c;

    // An hsync cycle itself sits at the reload phase, so its pixel lands in bin 12.
    assign phase_c   = vif.hsync ? JB_PHASE_W'(JB_PHASE_RELOAD) : cnt_q;
    assign bin_c     = phase_c[4:1];
    assign vs_rise_c = vif.vsync & ~vs_prev_q;
    assign tbl_sel_c = tbl_q[bin_c];

    video_jb_luma u_luma (
        .r       (vif.Ri),
        .g       (vif.Gi),
        .b       (vif.Bi),
        .luma8_c (luma_c)
    );

    always_comb begin
        for (int i = 0; i < int'(JB_BINS); i++) full_c[i] = cnt_bin_q[i][K];
    end

    // Per-bin average, its excess over the frame mean, clamped to 0..15.
    always_comb begin
        avg_c    = JB_PIX_W'(sum_q[idx_q] >> K);
        mean_c   = total_q[JB_TOT_W-1:4];
        diff_c   = {1'b0, avg_c} - {1'b0, mean_c};
        tbl_wr_c = diff_c[JB_PIX_W]      ? '0 :
                   (|diff_c[7:JB_TBL_W]) ? '1 : diff_c[JB_TBL_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d    = state_q;
        clr_c      = 1'b0;
        acc_en_c   = 1'b0;
        sum_en_c   = 1'b0;
        apply_en_c = 1'b0;
        lock_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise_c) begin
                    clr_c   = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (vs_rise_c) begin
                    // Incomplete frames are thrown away without touching the table.
                    if (&full_c) state_d = ST_SUM;
                    else         clr_c   = 1'b1;
                end else begin
                    acc_en_c = vif.de & ~full_c[bin_c];
                end
            end
            ST_SUM: begin
                sum_en_c = 1'b1;
                if (idx_q == JB_BIN_W'(JB_BINS - 1)) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                apply_en_c = 1'b1;
                if (idx_q == JB_BIN_W'(JB_BINS - 1)) begin
                    lock_set_c = 1'b1;
                    clr_c      = 1'b1;
                    state_d    = ST_ACCUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase counter, vsync history, update sequencer, lock flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            vs_prev_q <= 1'b1;  // first cycle out of reset never forms an edge
            idx_q     <= '0;
            total_q   <= '0;
            locked    <= 1'b0;
        end else begin
            cnt_q     <= phase_c + JB_PHASE_W'(1);
            vs_prev_q <= vif.vsync;
            if (sum_en_c || apply_en_c) idx_q <= idx_q + JB_BIN_W'(1);
            if (sum_en_c)
                total_q <= ((idx_q == '0) ? JB_TOT_W'(0) : total_q) + JB_TOT_W'(avg_c);
            if (lock_set_c) locked <= 1'b1;
        end
    end

    // Per-bin luma sums and saturating sample counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(JB_BINS); i++) begin
                sum_q[i]     <= '0;
                cnt_bin_q[i] <= '0;
            end
        end else if (clr_c) begin
            for (int i = 0; i < int'(JB_BINS); i++) begin
                sum_q[i]     <= '0;
                cnt_bin_q[i] <= '0;
            end
        end else if (acc_en_c) begin
            sum_q[bin_c]     <= sum_q[bin_c] + SUM_W'(luma_c);
            cnt_bin_q[bin_c] <= cnt_bin_q[bin_c] + CNT_W'(1);
        end
    end

    // Correction table.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(JB_BINS); i++) tbl_q[i] <= '0;
        end else if (apply_en_c) begin
            tbl_q[idx_q] <= tbl_wr_c;
        end
    end

    // Output stage: one register on pixels and syncs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vif.Ro      <= '0;
            vif.Go      <= '0;
            vif.Bo      <= '0;
            vif.hsync_o <= 1'b0;
            vif.vsync_o <= 1'b0;
            vif.de_o    <= 1'b0;
        end else begin
            vif.Ro      <= mode ? jb_sat_sub(vif.Ri, tbl_sel_c) : vif.Ri;
            vif.Go      <= mode ? jb_sat_sub(vif.Gi, tbl_sel_c) : vif.Gi;
            vif.Bo      <= mode ? jb_sat_sub(vif.Bi, tbl_sel_c) : vif.Bi;
            vif.hsync_o <= vif.hsync;
            vif.vsync_o <= vif.vsync;
            vif.de_o    <= vif.de;
        end
    end
endmodule

// File: tb/tb_video_viciie_jb_comp.sv
module tb_video_viciie_jb_comp;

    logic clk = 1'b0;
    logic reset_n;
    logic mode;
    logic locked;

    video_viciie_jb_comp_if vif ();

    video_viciie_jb_comp #(.K(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode),
        .vif     (vif),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cnt_m    = 0;
    logic [3:0]  tbl_m [16];
    logic [26:0] sb_q [$];

    function automatic logic [7:0] ref_out(input logic m, input logic [7:0] x, input logic [3:0] t);
        if (!m) return x;
        if (int'(x) < int'(t)) return 8'd0;
        return 8'(int'(x) - int'(t));
    endfunction

    function automatic int cur_bin(input logic hs);
        int ph;
        ph = hs ? 24 : cnt_m;
        return (ph / 2) % 16;
    endfunction

    task automatic check_vec(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) tbl_m[i] = 4'd0;
    endtask

    // Drive one pixel, record its expected output, compare one clock later.
    task automatic step(input string tag, input logic hs, input logic vs, input logic d,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [3:0] t;
        t = tbl_m[cur_bin(hs)];
        vif.hsync = hs; vif.vsync = vs; vif.de = d;
        vif.Ri = r; vif.Gi = g; vif.Bi = b;
        sb_q.push_back({ref_out(mode, r, t), ref_out(mode, g, t), ref_out(mode, b, t), hs, vs, d});
        cnt_m = ((hs ? 24 : cnt_m) + 1) % 64;
        @(posedge clk); #1;
        check_vec(tag, {vif.Ro, vif.Go, vif.Bo, vif.hsync_o, vif.vsync_o, vif.de_o}, sb_q.pop_front());
    endtask

    // Gray frame of 4 lines x 100 clocks; bump_bin pixels get +amt.
    task automatic frame(input string tag, input int bump_bin, input int amt);
        logic [7:0] v;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 100; j++) begin
                v = (cur_bin(j == 0) == bump_bin) ? 8'(100 + amt) : 8'd100;
                step(tag, j == 0, 1'b0, 1'b1, v, v, v);
            end
        end
    endtask

    // Long vblank: covers the 32-clock table update.
    task automatic vblank(input string tag);
        for (int i = 0; i < 40; i++) step(tag, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 2; i++)  step(tag, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic reset_pulse(input string tag);
        reset_n = 1'b0;
        #1;
        check_vec({tag, "_outs"}, {vif.Ro, vif.Go, vif.Bo, vif.hsync_o, vif.vsync_o, vif.de_o}, 27'd0);
        check_vec({tag, "_locked"}, 27'(locked), 27'd0);
        @(posedge clk); #1;
        check_vec({tag, "_outs_held"}, {vif.Ro, vif.Go, vif.Bo, vif.hsync_o, vif.vsync_o, vif.de_o}, 27'd0);
        reset_n = 1'b1;
        cnt_m   = 0;
        clear_tbl();
    endtask

    initial begin
        logic done;
        clear_tbl();
        mode = 1'b1;
        reset_n = 1'b0;
        vif.hsync = 1'b1; vif.vsync = 1'b1; vif.de = 1'b1;
        vif.Ri = 8'd77; vif.Gi = 8'd88; vif.Bi = 8'd99;
        repeat (3) @(posedge clk);
        #1;

        // 1: reset behaviour, first pixels after release, reset mid-stream
        reset_pulse("reset_init");
        for (int i = 0; i < 4; i++) step("post_reset", 1'b0, 1'b0, 1'b1, 8'(10 + i), 8'(20 + i), 8'(30 + i));
        vif.Ri = 8'd200; vif.Gi = 8'd201; vif.Bi = 8'd202; vif.de = 1'b1;
        #2;
        reset_pulse("reset_mid");
        step("first_after_release", 1'b0, 1'b0, 1'b1, 8'd55, 8'd66, 8'd77);

        // 2: bypass with random pixels and syncs
        mode = 1'b0;
        for (int i = 0; i < 24; i++)
            step("bypass_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 2; i++) step("bypass_tail", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        mode = 1'b1;

        // 3: flat gray locks with an all-zero table
        vblank("v_start");
        check_vec("locked_before_update", 27'(locked), 27'd0);
        frame("flat_learn", -1, 0);
        vblank("v_flat");
        check_vec("locked_after_flat", 27'(locked), 27'd1);
        frame("flat_check", -1, 0);

        // 4: +6 bar in bin 0 learned and removed
        vblank("v_flat2");
        frame("bar6_learn", 0, 6);
        vblank("v_bar6");
        tbl_m[0] = 4'd6;
        frame("bar6_corrected", 0, 6);
        vblank("v_bar6_again");

        // 5: short frame is discarded, table and lock unchanged
        for (int i = 0; i < 20; i++) step("short_frame", 1'b0, 1'b0, 1'b1, 8'd100, 8'd100, 8'd100);
        vblank("v_short");
        check_vec("locked_after_short", 27'(locked), 27'd1);

        // 6a: underflow floors at zero in bin 0
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (cur_bin(1'b0) == 0) begin
                step("underflow", 1'b0, 1'b0, 1'b1, 8'd3, 8'd200, 8'd5);
                done = 1'b1;
            end else begin
                step("short_check", 1'b0, 1'b0, 1'b1, 8'(cur_bin(1'b0) == 5 ? 140 : 100), 8'd100, 8'd100);
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $error("FAIL underflow_reach observed=no_bin0 expected=bin0");
        end
        vblank("v_discard");

        // 6b: +40 bar clamps to 15, bin 0 entry goes back to 0
        frame("bar40_learn", 5, 40);
        vblank("v_bar40");
        clear_tbl();
        tbl_m[5] = 4'd15;
        frame("bar40_corrected", 5, 40);

        // reset during the table update wipes table and lock
        for (int i = 0; i < 10; i++) step("v_update_cut", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        reset_pulse("reset_mid_sum");
        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = (cur_bin(1'b0) == 5) ? 8'd140 : 8'd100;
            step("after_cut", 1'b0, 1'b0, 1'b1, v, v, v);
        end
        check_vec("locked_after_cut", 27'(locked), 27'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_viciie_jb_comp.md
# video_vicIIe_jb_comp

Inverse of the C128 VIC IIe jailbar generator. The block measures the hsync-locked, 32-clock-periodic column brightening in an incoming RGB pixel stream and subtracts a learned per-phase offset from every pixel. It sits after video capture and before the scaler, and cleans up recorded or externally injected jailbar artefacts. Measurement runs over whole frames; the correction table updates once per frame during vblank.

## Interface
Parameters:
- K, 10, log2 of the number of samples averaged per phase bin per frame.

Ports:
- clk  in  1  pixel clock; one pixel per cycle.
- reset_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = bypass (registered pass-through), 1 = compensate.
- hsync  in  1  horizontal sync, active-high.
- vsync  in  1  vertical sync, active-high; the rising edge ends a frame.
- de  in  1  active-video qualifier.
- Ri, Gi, Bi  in  8 each  input pixel.
- Ro, Go, Bo  out  8 each  corrected pixel.
- hsync_o, vsync_o, de_o  out  1 each  syncs delayed to match the pixel data.
- locked  out  1  set after the first successful table update.

## Operation
- **Phase counter** (6 bits):
  - Loads 24 on any cycle with hsync = 1; otherwise increments and wraps 63 to 0.
  - Bin index = counter[4:1], giving 16 bins of 2 clocks each.
- **Luma**: luma8 = (Ri*10 + Gi*19 + Bi*3) >> 5.
  - Uses 13-bit products; the result fits 8 bits (max 255).
- **Per-bin storage**: a (8+K)-bit sum and a (K+1)-bit count for each bin.
  - A bin is full when count[K] = 1.
  - A sample is accumulated only when de = 1, state = ACCUM and the bin is not full.
  - Full bins ignore further samples; the sum cannot overflow.
- **FSM** (states IDLE, ACCUM, SUM, APPLY):
  - IDLE: entered from reset. On a vsync rising edge, clear all sums and counts and go to ACCUM.
  - ACCUM: on a vsync rising edge:
    - If all 16 bins are full, go to SUM.
    - Otherwise clear the sums and counts and stay in ACCUM; the frame is discarded and the table is unchanged.
  - SUM: 16 cycles, bins 0..15. Accumulate avg[b] = sum[b] >> K into a 12-bit total. Then go to APPLY.
  - APPLY: 16 cycles, bins 0..15.
    - mean = total >> 4.
    - d = avg[b] − mean, 9-bit signed.
    - table[b] = 0 if d < 0, 15 if d > 15, else d.
    - On the last cycle set locked = 1, clear the sums and counts, and go to ACCUM.
  - vsync edges during SUM or APPLY are ignored. The frame following the update is therefore partly lost and normally discarded.
- **Correction table**: 16 × 4 bits, all zero at reset.
  - mode does not affect measurement.
- **Output path**:
  - mode = 1: Xo = Xi − table[bin] when Xi ≥ table[bin], else 0. The same offset is applied to R, G and B.
  - mode = 0: Xo = Xi.
  - bin is the value at the cycle the pixel is sampled.
- **Mode changes** take effect on the next pixel; there is no glitch beyond a single-pixel transition.

## Timing
- Output latency is exactly 1 clock for Ro/Go/Bo, hsync_o, vsync_o and de_o.
- Reset values:
  - Ro/Go/Bo = 0, syncs = 0, de_o = 0, locked = 0.
  - Table = 0, counter = 0, state = IDLE, sums and counts = 0.
- vsync edge detection uses a registered previous-vsync. The first cycle after reset never counts as an edge.
- A table update completes 32 clocks after the qualifying vsync rising edge. New entries apply to the pixel sampled on the cycle after each entry's write.
- If hsync and de are both 1 in the same cycle, the pixel uses bin 12 (counter = 24) and is accumulated.
- Reset mid-SUM or mid-APPLY:
  - The table returns to zero and locked clears.
  - No partially written table survives.

## Structure
- Shared package video_jb_pkg holds:
  - the FSM state enum;
  - JB_PHASE_RELOAD = 24;
  - JB_BINS = 16;
  - the luma weights 10/19/3 and shift 5, shared with the generator.
- One sub-module, video_jb_luma: combinational luma8 from RGB, reused by the generator.
- Accumulator RAM/registers, FSM and output subtractor live in the top module.

## Test plan
1. Reset asserted mid-stream -> all outputs 0 and locked = 0 while reset_n = 0; the first output after release equals the input one clock later.
2. mode = 0, random RGB -> Ro/Go/Bo equal inputs delayed 1 clock, bit-exact; syncs delayed 1.
3. K = 4, flat gray 100/100/100 over full frames -> after the second vsync, locked = 1 and the table is all 0; output = input.
4. K = 4, gray 100 with +6 on all channels whenever counter[4:1] = 0:
   - mean computes to 100;
   - table[0] = 6, all others 0;
   - output is a flat 100 after the update.
5. Frame too short to fill bin 7 -> vsync leaves the table unchanged, the FSM stays in ACCUM and locked is unchanged.
6. Underflow and clamp:
   - table[0] = 6 with Ri = 3 in bin 0 -> Ro = 0;
   - a bar of +40 -> table entry clamps to 15.
